// File: rtl/addsub_serial_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The producer/consumer side uses master; the adder itself uses slave.
interface addsub_serial_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovfl;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport master (output in_valid, A, B, Cin, sub, out_ready,
                  input  in_ready, S, Cout, ovfl, zero, out_valid);
  modport slave  (input  in_valid, A, B, Cin, sub, out_ready,
                  output in_ready, S, Cout, ovfl, zero, out_valid);
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock over WIDTH/DIGIT cycles,
// with the inter-digit carry held in a register. Reports sum, Cout, ovfl and zero.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input logic          clk,
  input logic          rst_n,
  addsub_serial_if.slave io
);
  localparam int N  = (DIGIT < 1) ? 1 : WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("addsub_serial: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovfl_q, ovfl_d, zero_q, zero_d;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic [DIGIT:0]   dsum;
  logic             cin_msb;
  logic             last;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovfl_d  = ovfl_q;
    zero_d  = zero_q;

    dig_a   = DIGIT'(a_q >> (cnt_q * DIGIT));
    dig_b   = DIGIT'(b_q >> (cnt_q * DIGIT));
    dsum    = {1'b0, dig_a} + {1'b0, dig_b} + (DIGIT+1)'(carry_q);
    // Carry into the top bit of this digit; only meaningful on the last digit.
    cin_msb = dig_a[DIGIT-1] ^ dig_b[DIGIT-1] ^ dsum[DIGIT-1];
    last    = (cnt_q == CW'(N-1));

    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.A;
          b_d     = io.sub ? ~io.B : io.B;
          carry_d = io.Cin ^ io.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[cnt_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
        carry_d = dsum[DIGIT];
        if (last) begin
          cout_d  = dsum[DIGIT];
          ovfl_d  = cin_msb ^ dsum[DIGIT];
          zero_d  = (s_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
      zero_q  <= zero_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.S         = s_q;
  assign io.Cout      = cout_q;
  assign io.ovfl      = ovfl_q;
  assign io.zero      = zero_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: a 32/8 instance for the main scenarios and
// a 16/16 instance for the single-digit case.
module tb_addsub_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(32)) u_if ();
  addsub_serial_if #(.WIDTH(16)) u_if16 ();

  addsub_serial #(.WIDTH(32), .DIGIT(8))  u_dut   (.clk(clk), .rst_n(rst_n), .io(u_if));
  addsub_serial #(.WIDTH(16), .DIGIT(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .io(u_if16));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operation at a negedge and return just after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sb);
    @(negedge clk);
    check("in_ready_before_accept", 64'(u_if.in_ready), 64'd1);
    u_if.A = a; u_if.B = b; u_if.Cin = cin; u_if.sub = sb;
    u_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid, bounded.
  task automatic wait_done(input int exp_lat, input string tag);
    int lat = 0;
    while (!u_if.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_res(input string tag, input logic [31:0] s,
                           input logic co, input logic ov, input logic z);
    check({tag, "_S"},    64'(u_if.S),    64'(s));
    check({tag, "_Cout"}, 64'(u_if.Cout), 64'(co));
    check({tag, "_ovfl"}, 64'(u_if.ovfl), 64'(ov));
    check({tag, "_zero"}, 64'(u_if.zero), 64'(z));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_out_valid_drop"}, 64'(u_if.out_valid), 64'd0);
    check({tag, "_in_ready_rise"},  64'(u_if.in_ready),  64'd1);
    u_if.out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic cin, input logic sb, input logic [31:0] s,
                    input logic co, input logic ov, input logic z);
    start_op(a, b, cin, sb);
    wait_done(4, tag);
    check_res(tag, s, co, ov, z);
    release_out(tag);
  endtask

  initial begin
    u_if.in_valid = 0; u_if.A = '0; u_if.B = '0; u_if.Cin = 0; u_if.sub = 0; u_if.out_ready = 0;
    u_if16.in_valid = 0; u_if16.A = '0; u_if16.B = '0; u_if16.Cin = 0; u_if16.sub = 0;
    u_if16.out_ready = 0;

    #12;
    check("rst_in_ready",  64'(u_if.in_ready),  64'd1);
    check("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    check_res("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    op("ovf_add",   32'h7FFF_FFFF, 32'h1,          1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    op("borrow",    32'h5,         32'h7,          1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op("equal_sub", 32'h1234_5678, 32'h1234_5678,  1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1);
    op("chain",     32'h00FF_FFFF, 32'h1,          1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    op("chain_cin", 32'hFFFF_FFFF, 32'h0,          1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);

    // Backpressure: result must hold while inputs churn.
    start_op(32'h10, 32'h20, 1'b0, 1'b0);
    wait_done(4, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      u_if.in_valid = i[0];
      u_if.A = $urandom;
      u_if.B = $urandom;
      u_if.sub = i[1];
      check("bp_hold_S",        64'(u_if.S),         64'h30);
      check("bp_hold_in_ready", 64'(u_if.in_ready),  64'd0);
      check("bp_hold_valid",    64'(u_if.out_valid), 64'd1);
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
    check_res("bp", 32'h30, 1'b0, 1'b0, 1'b0);
    release_out("bp");
    op("bp_next", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Reset during the digit-2 cycle (between the 2nd and 3rd edges after accept).
    start_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(u_if.out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(u_if.in_ready),  64'd1);
    check_res("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    op("after_rst", 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0);

    // Single-digit instance: out_valid one edge after accept.
    begin
      int lat = 0;
      @(negedge clk);
      check("w16_in_ready", 64'(u_if16.in_ready), 64'd1);
      u_if16.A = 16'hFFFF; u_if16.B = 16'h0; u_if16.Cin = 1'b1; u_if16.sub = 1'b0;
      u_if16.in_valid = 1'b1;
      @(posedge clk);
      #1;
      u_if16.in_valid = 1'b0;
      while (!u_if16.out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("w16_latency", 64'(lat),            64'd1);
      check("w16_S",       64'(u_if16.S),       64'h0);
      check("w16_Cout",    64'(u_if16.Cout),    64'd1);
      check("w16_ovfl",    64'(u_if16.ovfl),    64'd0);
      check("w16_zero",    64'(u_if16.zero),    64'd1);
      check("w16_no_in_ready", 64'(u_if16.in_ready), 64'd0);
      @(negedge clk);
      u_if16.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("w16_out_valid_drop", 64'(u_if16.out_valid), 64'd0);
      u_if16.out_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial adder/subtractor with valid/ready handshakes on both sides. It replaces fixed-width combinational ripple adders wherever WIDTH is large enough that a single-cycle carry chain breaks timing. Each operation processes DIGIT bits per clock over WIDTH/DIGIT cycles. The carry between digits is kept in a register. The block reports sum, carry-out, signed overflow and zero.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 8: bits added per clock, 1..WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  block can accept an operation.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in (borrow-in when sub=1).
- sub  in  1  0: A+B+Cin; 1: A-B-Cin.
- S  out  WIDTH  result.
- Cout  out  1  raw carry out of bit WIDTH-1.
- ovfl  out  1  two's-complement overflow.
- zero  out  1  S == 0.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.

## Operation
- N = WIDTH/DIGIT. Elaboration fails if WIDTH % DIGIT != 0 or DIGIT < 1.
- States:
  - IDLE: in_ready=1.
  - RUN: counter 0..N-1.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid && in_ready.
  - At this edge, latch A and B, with B inverted when sub=1.
  - Set the carry register to Cin ^ sub.
  - Clear the digit counter.
- RUN, each cycle:
  - Add digit k of latched A and latched B plus the carry register.
  - Store DIGIT sum bits into S bits [k*DIGIT +: DIGIT].
  - Update the carry register.
  - Increment k.
- RUN→DONE after digit N-1.
  - On this edge, Cout takes the final carry.
  - ovfl takes carry-into-MSB XOR carry-out of the MSB. The carry-into-MSB is captured during digit N-1.
  - zero takes (final S == 0).
- DONE→IDLE on out_ready; S and flags hold their values until the next operation's RUN overwrites them.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- sub=1 with Cin=0 gives A-B. Cout=1 means no borrow.
- Reset, asynchronous and effective at any time including mid-RUN:
  - state=IDLE.
  - S, Cout, ovfl and zero are 0; out_valid=0.
  - Latched operands, carry register and counter are 0.
  - in_ready=1 from reset, as it is a decode of IDLE.

## Timing
- Accept edge E0. Digits 0..N-1 are processed on edges E1..EN. out_valid is high after EN, i.e. N cycles after acceptance.
- DIGIT=WIDTH gives single-digit operation, with out_valid one cycle after accept.
- out_valid and in_ready are never high together.
- in_ready rises the cycle after the output handshake, so throughput is one operation per N+2 cycles with out_ready tied high.
- S, Cout, ovfl and zero are stable for the whole time out_valid=1, regardless of input activity.
- S bits may change during RUN and are meaningful only while out_valid=1.
- All outputs are registered or are state decodes, with no combinational path from A/B to S.
- The critical path is one DIGIT-bit adder plus the carry register.

## Test plan
All scenarios use WIDTH=32, DIGIT=8, N=4 unless stated.
- Signed overflow: A=0x7FFFFFFF, B=1, sub=0, Cin=0 → S=0x80000000, ovfl=1, Cout=0, zero=0. out_valid rises exactly 4 cycles after the accept edge.
- Subtraction with borrow: A=5, B=7, sub=1, Cin=0 → S=0xFFFFFFFE, Cout=0, ovfl=0, zero=0.
- Equal subtraction: A=B=0x12345678, sub=1, Cin=0 → S=0, zero=1, Cout=1, ovfl=0.
- Inter-digit carry chain: A=0x00FFFFFF, B=1 → S=0x01000000, Cout=0. Also A=0xFFFFFFFF, B=0, Cin=1 → S=0, Cout=1, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid, A and B.
  - S and flags stay stable and in_ready=0 throughout.
  - Raising out_ready makes out_valid drop on the next edge, with in_ready=1.
  - A second operation accepted then completes correctly.
- Reset mid-operation: deassert rst_n asynchronously during the RUN cycle for digit 2.
  - Outputs immediately show 0 with out_valid=0 and in_ready=1.
  - After release, A=1, B=2 → S=3.
  - Repeat the Cin=1 case of the carry-chain scenario at WIDTH=DIGIT=16 → out_valid one cycle after accept.
